// File: rtl/lms_pkg.sv
// lms_pkg: shared FSM state codes, width derivation helpers and signed saturation
package lms_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILT   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_ERR    = 3'd3;
  localparam logic [2:0] ST_UPD    = 3'd4;
  localparam logic [2:0] ST_UDRAIN = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  function automatic int aw(input int taps);
    return $clog2(taps);
  endfunction
  function automatic int accw(input int xw, input int ww, input int taps);
    return xw + ww + aw(taps);
  endfunction
  function automatic int ew(input int xw, input int taps);
    return 2 * xw + aw(taps);
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
endpackage

// File: rtl/lms_mac_lane.sv
// lms_mac_lane: registered w*x and x*x products feeding dot-product and energy accumulators
module lms_mac_lane #(
  parameter int XW = 14,
  parameter int WW = 16,
  parameter int ACCW = 35,
  parameter int EW = 33
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic [XW-1:0]   x,
  input  logic [WW-1:0]   w,
  output logic [ACCW-1:0] acc,
  output logic [EW-1:0]   energy
);
  logic signed [XW+WW-1:0] p;
  logic [2*XW-1:0] s;
  logic pv;
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      p <= '0;
      s <= '0;
      pv <= 1'b0;
      acc <= '0;
      energy <= '0;
    end else begin
      pv <= en;
      p <= $signed(x) * $signed(w);
      s <= $signed(x) * $signed(x);
      if (pv) begin
        acc <= acc + ACCW'(p);
        energy <= energy + EW'(s);
      end
    end
  end
endmodule

// File: rtl/lms_tap_engine.sv
// lms_tap_engine: serial adaptive-FIR run with optional LMS weight-update pass
module lms_tap_engine import lms_pkg::*; #(
  parameter int TAPS = 32,
  parameter int XW = 14,
  parameter int WW = 16,
  parameter int SHIFT = 15,
  parameter int MU_SHIFT = 10,
  parameter int UPDATE_EN = 1,
  localparam int AW = aw(TAPS),
  localparam int ACCW = accw(XW, WW, TAPS),
  localparam int EW = ew(XW, TAPS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          update,
  input  logic [XW-1:0] desired,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [XW-1:0] x_rd,
  input  logic [WW-1:0] w_rd,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [WW-1:0] w_wr,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] y,
  output logic [XW-1:0] e,
  output logic [EW-1:0] energy,
  output logic          y_sat,
  output logic          e_sat
);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  logic [2:0] state;
  logic [AW-1:0] cnt, a_q;
  logic upd, rd_q, up_q;
  logic [XW-1:0] des;
  logic [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_sh;
  logic signed [XW:0] diff;
  logic signed [2*XW-1:0] ex, dlt;
  logic signed [63:0] y_full, e_full, wsum;
  lms_mac_lane #(.XW(XW), .WW(WW), .ACCW(ACCW), .EW(EW)) mac (
    .clk(clk), .rstn(rstn), .clr(state == ST_IDLE && start), .en(rd_q && !up_q),
    .x(x_rd), .w(w_rd), .acc(acc), .energy(energy)
  );
  assign rd_en = state == ST_FILT || state == ST_UPD;
  assign rd_addr = cnt;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  always_comb begin
    acc_sh = $signed(acc) >>> SHIFT;
    y_full = sat(64'(acc_sh), XW);
    diff = $signed({des[XW-1], des}) - $signed({y[XW-1], y});
    e_full = sat(64'(diff), XW);
    ex = $signed(e) * $signed(x_rd);
    dlt = ex >>> MU_SHIFT;
    wsum = 64'($signed(w_rd)) + 64'(dlt);
  end
  // rd_q/up_q/a_q track the read issued last cycle, whose data is on x_rd/w_rd now
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt <= '0;
      upd <= 1'b0;
      des <= '0;
      rd_q <= 1'b0;
      up_q <= 1'b0;
      a_q <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      w_wr <= '0;
      y <= '0;
      e <= '0;
      y_sat <= 1'b0;
      e_sat <= 1'b0;
    end else begin
      rd_q <= rd_en;
      up_q <= state == ST_UPD;
      a_q <= cnt;
      wr_en <= rd_q && up_q;
      if (rd_q && up_q) begin
        wr_addr <= a_q;
        w_wr <= WW'(sat(wsum, WW));
      end
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_FILT;
          cnt <= '0;
          des <= desired;
          upd <= update && UPDATE_EN != 0;
        end
        ST_FILT, ST_UPD: begin
          cnt <= cnt == LAST ? '0 : cnt + AW'(1);
          if (cnt == LAST) state <= state == ST_FILT ? ST_DRAIN : ST_UDRAIN;
        end
        ST_DRAIN, ST_UDRAIN: begin
          cnt <= cnt == AW'(1) ? '0 : cnt + AW'(1);
          if (cnt == AW'(1)) state <= state == ST_DRAIN ? ST_ERR : ST_DONE;
        end
        // y settles first so e can be formed from the saturated y
        ST_ERR: if (cnt == '0) begin
          y <= XW'(y_full);
          y_sat <= y_full != 64'(acc_sh);
          cnt <= AW'(1);
        end else begin
          e <= XW'(e_full);
          e_sat <= e_full != 64'(diff);
          cnt <= '0;
          state <= upd ? ST_UPD : ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lms_tap_engine.sv
// tb_lms_tap_engine: directed and random runs against an arithmetic reference model
module tb_lms_tap_engine;
  localparam int TAPS = 32;
  localparam int XW = 14;
  localparam int WW = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic update = 1'b0;
  logic [XW-1:0] desired = '0;
  logic [XW-1:0] x_rd, y, e;
  logic [WW-1:0] w_rd, w_wr;
  logic rd_en, wr_en, busy, done, y_sat, e_sat;
  logic [4:0] rd_addr, wr_addr;
  logic [32:0] energy;
  int checks = 0;
  int errors = 0;
  longint xm[TAPS], wm[TAPS], exp_w[TAPS];
  longint exp_y, exp_e, exp_en;
  bit exp_ys, exp_es;

  lms_tap_engine dut (
    .clk(clk), .rstn(rstn), .start(start), .update(update), .desired(desired),
    .rd_en(rd_en), .rd_addr(rd_addr), .x_rd(x_rd), .w_rd(w_rd),
    .wr_en(wr_en), .wr_addr(wr_addr), .w_wr(w_wr), .busy(busy), .done(done),
    .y(y), .e(e), .energy(energy), .y_sat(y_sat), .e_sat(e_sat)
  );

  always #5 clk = ~clk;

  // sample/weight buffers with one-cycle read latency
  always @(posedge clk) if (rd_en) begin
    x_rd <= XW'(xm[rd_addr]);
    w_rd <= WW'(wm[rd_addr]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint clamp(input longint v, input int n);
    longint hi = (longint'(1) << (n - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  function automatic longint rnd(input int n);
    longint v = longint'($urandom);
    return (v << (64 - n)) >>> (64 - n);
  endfunction

  task automatic model(input bit upd, input longint des);
    longint acc = 0;
    longint ys;
    exp_en = 0;
    foreach (xm[k]) begin
      acc += xm[k] * wm[k];
      exp_en += xm[k] * xm[k];
    end
    ys = acc >>> 15;
    exp_y = clamp(ys, XW);
    exp_ys = exp_y != ys;
    exp_e = clamp(des - exp_y, XW);
    exp_es = exp_e != des - exp_y;
    foreach (wm[k]) exp_w[k] = upd ? clamp(wm[k] + ((exp_e * xm[k]) >>> 10), WW) : wm[k];
  endtask

  task automatic run(input bit upd, input longint des, input int pulse_at);
    int done_at = -1;
    int nw = 0;
    model(upd, des);
    desired = XW'(des);
    update = upd;
    start = 1'b1;
    tick();
    start = 1'b0;
    update = 1'b0;
    desired = XW'($urandom);
    for (int c = 1; c <= 3 * TAPS + 20 && done_at < 0; c++) begin
      if (c == 1) begin
        chk("busy_c1", busy, 1);
        chk("rd_en_c1", rd_en, 1);
        chk("rd_addr_c1", rd_addr, 0);
      end
      if (wr_en) begin
        chk("wr_addr", wr_addr, nw);
        chk("w_wr", $signed(w_wr), exp_w[nw % TAPS]);
        chk("wr_cycle", c, TAPS + 7 + nw);
        nw++;
      end
      if (done) begin
        done_at = c;
        chk("y", $signed(y), exp_y);
        chk("e", $signed(e), exp_e);
        chk("energy", energy, exp_en);
        chk("y_sat", y_sat, exp_ys);
        chk("e_sat", e_sat, exp_es);
      end
      start = done || c == pulse_at;
      tick();
    end
    start = 1'b0;
    chk("done_cycle", done_at, upd ? 2 * TAPS + 7 : TAPS + 5);
    chk("write_count", nw, upd ? TAPS : 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_y", y, 0);
    chk("rst_energy", energy, 0);
    rstn = 1'b1;
    tick();

    foreach (xm[k]) begin xm[k] = 2; wm[k] = 16384; end
    run(0, 100, 0);
    chk("tp1_y", $signed(y), 32);
    chk("tp1_e", $signed(e), 68);
    chk("tp1_energy", energy, 128);
    chk("tp1_flags", {y_sat, e_sat}, 0);

    foreach (xm[k]) begin xm[k] = 8191; wm[k] = 32767; end
    run(0, -8192, 0);
    chk("tp2_y", $signed(y), 8191);
    chk("tp2_e", $signed(e), -8192);
    chk("tp2_flags", {y_sat, e_sat}, 3);

    foreach (xm[k]) begin xm[k] = 0; wm[k] = 0; end
    xm[0] = -1;
    wm[0] = 1;
    run(0, -300, 5);
    chk("tp3_y", $signed(y), -1);
    chk("tp3_e", $signed(e), -299);

    foreach (xm[k]) begin xm[k] = 64; wm[k] = 0; end
    run(1, 1000, 0);
    chk("tp4_y", $signed(y), 0);
    chk("tp4_e", $signed(e), 1000);
    chk("tp4_wlast", $signed(w_wr), 62);

    foreach (xm[k]) begin xm[k] = 0; wm[k] = 32760; end
    xm[0] = 8191;
    wm[0] = 0;
    xm[1] = 8191;
    xm[2] = -8191;
    run(1, 8191, 0);
    chk("tp5_e", $signed(e), 8191);

    for (int r = 0; r < 4; r++) begin
      foreach (xm[k]) begin
        xm[k] = rnd(XW);
        wm[k] = r < 2 ? rnd(11) : rnd(WW);
      end
      run(r[0], rnd(XW), r == 2 ? 7 : 0);
    end

    start = 1'b1;
    update = 1'b1;
    desired = 14'd500;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      start = c == 5;
      rstn = c != 10;
      tick();
    end
    start = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_rd_en", rd_en, 0);
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_w_wr", w_wr, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_e", e, 0);
    chk("mid_rst_energy", energy, 0);
    chk("mid_rst_flags", {y_sat, e_sat, done}, 0);
    rstn = 1'b1;
    tick();

    foreach (xm[k]) begin xm[k] = rnd(XW); wm[k] = rnd(12); end
    run(1, rnd(XW), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
